// File: rtl/row_packer_pkg.sv
// Shared constants and state encoding for the row packer.
// Defaults describe the production 256x256 RGB888 configuration.
package row_packer_pkg;

  localparam int unsigned COLS  = 256;
  localparam int unsigned ROWS  = 256;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned PIX_W = 3 * WIDTH;
  localparam int unsigned ROW_W = COLS * PIX_W;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill  = 2'd1,
    StStall = 2'd2
  } state_e;

endpackage

// File: rtl/row_packer_if.sv
// Pixel-in / row-out handshake bundle between the pixel source, the packer and the row filter.
// The slave modport is the packer's view; master is the surrounding environment's view.
interface row_packer_if
  import row_packer_pkg::*;
#(
  parameter int unsigned Cols  = COLS,
  parameter int unsigned Width = WIDTH
);

  logic [3*Width-1:0]      pix_in;
  logic                    pix_valid;
  logic                    pix_sof;
  logic                    pix_ready;
  logic [Cols*3*Width-1:0] row_out;
  logic                    row_valid;
  logic                    row_ready;
  logic                    row_first;
  logic                    row_last;
  logic                    sof_err;

  modport master (
    output pix_in, pix_valid, pix_sof, row_ready,
    input  pix_ready, row_out, row_valid, row_first, row_last, sof_err
  );

  modport slave (
    input  pix_in, pix_valid, pix_sof, row_ready,
    output pix_ready, row_out, row_valid, row_first, row_last, sof_err
  );

endinterface

// File: rtl/row_fill_buffer.sv
// Column-addressed pixel store holding the row currently being assembled.
// Read side is the whole row flattened with column 0 in the most significant bits.
module row_fill_buffer #(
  parameter int unsigned Cols = 256,
  parameter int unsigned PixW = 24,
  parameter int unsigned ColW = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 wr_en,
  input  logic [ColW-1:0]      wr_col,
  input  logic [PixW-1:0]      wr_data,
  output logic [Cols*PixW-1:0] row
);

  logic [PixW-1:0] mem_q [Cols];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < int'(Cols); i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_col] <= wr_data;
    end
  end

  for (genvar g = 0; g < int'(Cols); g++) begin : g_flat
    assign row[(int'(Cols) - 1 - g) * int'(PixW) +: int'(PixW)] = mem_q[g];
  end

endmodule

// File: rtl/row_packer.sv
// Packs a raster pixel stream into one wide word per image row, with a fill buffer
// backed by an output register so the next row can fill while the last one waits.
module row_packer
  import row_packer_pkg::*;
#(
  parameter int unsigned Cols  = COLS,
  parameter int unsigned Rows  = ROWS,
  parameter int unsigned Width = WIDTH
) (
  input logic         CLK,
  input logic         RST,
  row_packer_if.slave bus
);

  localparam int unsigned PixW    = 3 * Width;
  localparam int unsigned RowW    = Cols * PixW;
  localparam int unsigned ColW    = (Cols > 1) ? $clog2(Cols) : 1;
  localparam int unsigned RowCntW = (Rows > 1) ? $clog2(Rows) : 1;
  localparam logic [ColW-1:0]    LastCol = ColW'(Cols - 1);
  localparam logic [RowCntW-1:0] LastRow = RowCntW'(Rows - 1);

  state_e              state_q, state_d;
  logic [ColW-1:0]     col_q, col_d;
  logic [RowCntW-1:0]  row_q, row_d;
  logic [RowW-1:0]     row_out_q, row_out_d;
  logic                row_valid_q, row_valid_d;
  logic                row_first_q, row_first_d;
  logic                row_last_q, row_last_d;
  logic                sof_err_q, sof_err_d;

  logic                wr_en;
  logic [ColW-1:0]     wr_col;
  logic [RowW-1:0]     fill_row;
  logic                accept, out_free, do_load;
  logic [ColW-1:0]     eff_col;
  logic [RowCntW-1:0]  eff_row, load_row;
  logic [RowW-1:0]     load_data;

  row_fill_buffer #(
    .Cols (Cols),
    .PixW (PixW),
    .ColW (ColW)
  ) u_fill (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (wr_en),
    .wr_col  (wr_col),
    .wr_data (bus.pix_in),
    .row     (fill_row)
  );

  assign accept   = bus.pix_valid && (state_q != StStall);
  assign out_free = !row_valid_q || bus.row_ready;
  // A sof pixel always restarts at the frame origin, whatever the counters say.
  assign eff_col  = bus.pix_sof ? '0 : col_q;
  assign eff_row  = bus.pix_sof ? '0 : row_q;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    row_out_d   = row_out_q;
    row_valid_d = row_valid_q && !bus.row_ready;
    row_first_d = row_first_q;
    row_last_d  = row_last_q;
    sof_err_d   = 1'b0;
    wr_en       = 1'b0;
    wr_col      = col_q;
    do_load     = 1'b0;
    load_row    = row_q;
    load_data   = fill_row;

    unique case (state_q)
      StIdle, StFill: begin
        if (accept && (bus.pix_sof || state_q == StFill)) begin
          sof_err_d = bus.pix_sof && (state_q == StFill) && (col_q != '0 || row_q != '0);
          wr_en     = 1'b1;
          wr_col    = eff_col;
          state_d   = StFill;
          col_d     = eff_col + 1'b1;
          row_d     = eff_row;
          if (eff_col == LastCol) begin
            if (out_free) begin
              // Last pixel bypasses the buffer so the row lands with no extra cycle.
              do_load   = 1'b1;
              load_row  = eff_row;
              load_data = {fill_row[RowW-1:PixW], bus.pix_in};
            end else begin
              state_d = StStall;
              col_d   = eff_col;
            end
          end
        end
      end
      StStall: begin
        if (bus.row_ready) do_load = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (do_load) begin
      row_out_d   = load_data;
      row_valid_d = 1'b1;
      row_first_d = (load_row == '0);
      row_last_d  = (load_row == LastRow);
      col_d       = '0;
      if (load_row == LastRow) begin
        row_d   = '0;
        state_d = StIdle;
      end else begin
        row_d   = load_row + 1'b1;
        state_d = StFill;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      col_q       <= '0;
      row_q       <= '0;
      row_out_q   <= '0;
      row_valid_q <= 1'b0;
      row_first_q <= 1'b0;
      row_last_q  <= 1'b0;
      sof_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      row_out_q   <= row_out_d;
      row_valid_q <= row_valid_d;
      row_first_q <= row_first_d;
      row_last_q  <= row_last_d;
      sof_err_q   <= sof_err_d;
    end
  end

  assign bus.pix_ready = (state_q != StStall);
  assign bus.row_out   = row_out_q;
  assign bus.row_valid = row_valid_q;
  assign bus.row_first = row_first_q;
  assign bus.row_last  = row_last_q;
  assign bus.sof_err   = sof_err_q;

endmodule

// File: tb/tb_row_packer.sv
// Scoreboard bench for row_packer in a 4x4 RGB888 configuration: stimulus queues the
// expected rows, a negedge monitor checks each consumed row against the queue head.
module tb_row_packer;

  logic CLK;
  logic RST;

  row_packer_if #(.Cols(4), .Width(8)) bus ();

  row_packer #(
    .Cols  (4),
    .Rows  (4),
    .Width (8)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic [95:0] row;
    logic        first;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   checks      = 0;
  int   failures    = 0;
  int   sof_pulses  = 0;
  int   stall_waits = 0;
  bit   done        = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push4(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c,
                       input logic [23:0] d, input logic first, input logic last);
    exp_t e;
    e.row   = {a, b, c, d};
    e.first = first;
    e.last  = last;
    exp_q.push_back(e);
  endtask

  // Holds the pixel until the edge that accepts it, returns 1ns after that edge.
  task automatic send(input logic [23:0] d, input logic sof);
    bit rdy;
    int budget;
    bus.pix_in    = d;
    bus.pix_sof   = sof;
    bus.pix_valid = 1'b1;
    budget        = 0;
    do begin
      @(negedge CLK);
      rdy = bus.pix_ready;
      @(posedge CLK);
      #1;
      if (!rdy) stall_waits++;
      budget++;
    end while (!rdy && budget < 100);
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got pix_ready=0 required pix_ready=1 within 100 cycles");
    end
  endtask

  task automatic idle_cycles(input int n);
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Monitor: one pop per consumed row, plus sof_err pulse counting.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge CLK);
      if (!RST && bus.sof_err) sof_pulses++;
      if (!RST && bus.row_valid && bus.row_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_row: got row %0h required no row", bus.row_out);
        end else begin
          e = exp_q.pop_front();
          chk("row_data", 128'(bus.row_out), 128'(e.row));
          chk("row_first", 128'(bus.row_first), 128'(e.first));
          chk("row_last", 128'(bus.row_last), 128'(e.last));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish within 200000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits0;
    RST           = 1'b1;
    bus.pix_in    = '0;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.row_ready = 1'b1;
    #12;
    chk("rst_row_valid", 128'(bus.row_valid), 128'(0));
    chk("rst_row_out", 128'(bus.row_out), 128'(0));
    chk("rst_first_last", 128'({bus.row_first, bus.row_last}), 128'(0));
    chk("rst_sof_err", 128'(bus.sof_err), 128'(0));
    chk("rst_pix_ready", 128'(bus.pix_ready), 128'(1));
    @(posedge CLK);
    #1;
    RST = 1'b0;
    idle_cycles(1);

    // Frame A: two pre-sof pixels must be dropped, then a sustained 16-pixel frame.
    push4(24'h000001, 24'h000002, 24'h000003, 24'h000004, 1'b1, 1'b0);
    push4(24'h000005, 24'h000006, 24'h000007, 24'h000008, 1'b0, 1'b0);
    push4(24'h000009, 24'h00000a, 24'h00000b, 24'h00000c, 1'b0, 1'b0);
    push4(24'h00000d, 24'h00000e, 24'h00000f, 24'h000010, 1'b0, 1'b1);
    send(24'haaaaaa, 1'b0);
    send(24'hbbbbbb, 1'b0);
    waits0 = stall_waits;
    for (int i = 1; i <= 16; i++) begin
      send(24'(i), i == 1);
      if (i % 4 == 0) chk("latency_row_valid", 128'(bus.row_valid), 128'(1));
    end
    chk("frame_a_no_bubble", 128'(stall_waits - waits0), 128'(0));
    idle_cycles(2);

    // Frame B: row 0 held, row 1 completes into STALL, released by a one-cycle row_ready.
    push4(24'h000011, 24'h000012, 24'h000013, 24'h000014, 1'b1, 1'b0);
    push4(24'h000015, 24'h000016, 24'h000017, 24'h000018, 1'b0, 1'b0);
    push4(24'h000019, 24'h00001a, 24'h00001b, 24'h00001c, 1'b0, 1'b0);
    push4(24'h00001d, 24'h00001e, 24'h00001f, 24'h000020, 1'b0, 1'b1);
    bus.row_ready = 1'b0;
    for (int i = 'h11; i <= 'h18; i++) send(24'(i), i == 'h11);
    chk("stall_pix_ready_drop", 128'(bus.pix_ready), 128'(0));
    idle_cycles(2);
    chk("stall_pix_ready_hold", 128'(bus.pix_ready), 128'(0));
    chk("stall_row_valid_hold", 128'(bus.row_valid), 128'(1));
    bus.row_ready = 1'b1;
    @(posedge CLK);
    #1;
    bus.row_ready = 1'b0;
    chk("stall_exit_pix_ready", 128'(bus.pix_ready), 128'(1));
    chk("stall_exit_row_valid", 128'(bus.row_valid), 128'(1));
    bus.row_ready = 1'b1;
    for (int i = 'h19; i <= 'h20; i++) send(24'(i), 1'b0);
    idle_cycles(2);

    // Frame C: sof on the third pixel of row 1 resynchronises the frame.
    push4(24'h000021, 24'h000022, 24'h000023, 24'h000024, 1'b1, 1'b0);
    push4(24'h000027, 24'h000028, 24'h000029, 24'h00002a, 1'b1, 1'b0);
    for (int i = 'h21; i <= 'h26; i++) send(24'(i), i == 'h21);
    chk("sof_err_quiet", 128'(bus.sof_err), 128'(0));
    send(24'h000027, 1'b1);
    chk("sof_err_pulse", 128'(bus.sof_err), 128'(1));
    send(24'h000028, 1'b0);
    chk("sof_err_one_cycle", 128'(bus.sof_err), 128'(0));
    send(24'h000029, 1'b0);
    send(24'h00002a, 1'b0);
    idle_cycles(1);

    // Reset with a held row and a partial row at col=2; neither may survive.
    bus.row_ready = 1'b0;
    for (int i = 'h2b; i <= 'h30; i++) send(24'(i), 1'b0);
    bus.pix_valid = 1'b0;
    chk("pre_reset_row_valid", 128'(bus.row_valid), 128'(1));
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst_row_valid", 128'(bus.row_valid), 128'(0));
    chk("async_rst_row_out", 128'(bus.row_out), 128'(0));
    chk("async_rst_first_last", 128'({bus.row_first, bus.row_last}), 128'(0));
    chk("async_rst_pix_ready", 128'(bus.pix_ready), 128'(1));
    @(posedge CLK);
    #1;
    RST           = 1'b0;
    bus.row_ready = 1'b1;
    idle_cycles(1);

    // Frames D and E back to back after reset; a non-sof pixel first is dropped.
    push4(24'h000031, 24'h000032, 24'h000033, 24'h000034, 1'b1, 1'b0);
    push4(24'h000035, 24'h000036, 24'h000037, 24'h000038, 1'b0, 1'b0);
    push4(24'h000039, 24'h00003a, 24'h00003b, 24'h00003c, 1'b0, 1'b0);
    push4(24'h00003d, 24'h00003e, 24'h00003f, 24'h000040, 1'b0, 1'b1);
    push4(24'h000041, 24'h000042, 24'h000043, 24'h000044, 1'b1, 1'b0);
    push4(24'h000045, 24'h000046, 24'h000047, 24'h000048, 1'b0, 1'b0);
    push4(24'h000049, 24'h00004a, 24'h00004b, 24'h00004c, 1'b0, 1'b0);
    push4(24'h00004d, 24'h00004e, 24'h00004f, 24'h000050, 1'b0, 1'b1);
    send(24'heeeeee, 1'b0);
    waits0 = stall_waits;
    for (int i = 'h31; i <= 'h50; i++) send(24'(i), (i == 'h31) || (i == 'h41));
    chk("frames_de_no_bubble", 128'(stall_waits - waits0), 128'(0));
    idle_cycles(4);

    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    chk("sof_err_total", 128'(sof_pulses), 128'(1));
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
